// File: rtl/servo_sched.sv
// -----------------------------------------------------------------------------
// servo_sched
//   Shares one servo pulse generator between two requesters (A, B). Requests
//   are arbitrated round-robin and granted one at a time. Each accepted
//   position change is held for HOLD_FRAMES servo frames so the horn can
//   settle before the next grant.
//
//   Optional feature (compile-time macro SWEEP_EN): after IDLE_FRAMES idle
//   frames the block runs an auto-sweep 0,2,1,2,0 with STEP_FRAMES frames per
//   step. Any request aborts the sweep.
//
// Parameters
//   HOLD_FRAMES  frames a new position is held before the next grant (1..255)
//   IDLE_FRAMES  idle frames before an auto-sweep starts (SWEEP_EN only)
//   STEP_FRAMES  frames per sweep step (SWEEP_EN only)
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   frame_tick  one-clk pulse per servo frame
//   req[1:0]    req[0]=A, req[1]=B; held high until the matching gnt
//   pos_a/pos_b requested positions (3 is treated as 0)
//   gnt[1:0]    one-clk grant pulse, one-hot or zero (registered)
//   busy        high while holding a position or sweeping (registered)
//   sel[1:0]    position select: 0=1ms, 1=2ms, 2=1.5ms (registered)
// -----------------------------------------------------------------------------
module servo_sched #(
   parameter int unsigned HOLD_FRAMES = 25,
   parameter int unsigned IDLE_FRAMES = 50,
   parameter int unsigned STEP_FRAMES = 25
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic [1:0] req,
   input  logic [1:0] pos_a,
   input  logic [1:0] pos_b,
   output logic [1:0] gnt,
   output logic       busy,
   output logic [1:0] sel
);

   if (HOLD_FRAMES < 1 || HOLD_FRAMES > 255 ||
       IDLE_FRAMES < 1 || IDLE_FRAMES > 255 ||
       STEP_FRAMES < 1 || STEP_FRAMES > 255) begin : g_bad_params
      $error("servo_sched: frame parameters must lie in 1..255");
   end

`ifdef SWEEP_EN
   typedef enum logic [1:0] {IDLE, HOLD, SWEEP} state_t;
   localparam logic [7:0] IDLE_LAST = 8'(IDLE_FRAMES - 1);
   localparam logic [7:0] STEP_LAST = 8'(STEP_FRAMES - 1);
`else
   typedef enum logic {IDLE, HOLD} state_t;
`endif
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

   state_t     state_q, state_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic       last_gnt_q, last_gnt_d;   // 1 = B was granted last
   logic [1:0] gnt_d, sel_d;
   logic       busy_d;
   logic [1:0] elig;
   logic       win_b;
   logic [1:0] win_pos;
`ifdef SWEEP_EN
   logic [7:0] idle_cnt_q, idle_cnt_d;
   logic [2:0] step_q, step_d;
`endif

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [1:0] map_pos(input logic [1:0] p);
      return (p == 2'd3) ? 2'd0 : p;
   endfunction

`ifdef SWEEP_EN
   function automatic logic [1:0] sweep_pos(input logic [2:0] step);
      case (step)
         3'd1, 3'd3: return 2'd2;
         3'd2:       return 2'd1;
         default:    return 2'd0;
      endcase
   endfunction
`endif

   // A requester still shows req high in the cycle its gnt is high; masking
   // it stops a no-op grant from being issued twice for the same request.
   assign elig    = req & ~gnt;
   assign win_b   = elig[1] & (~elig[0] | ~last_gnt_q);
   assign win_pos = map_pos(win_b ? pos_b : pos_a);

   // NOTE: every signal assigned here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      last_gnt_d  = last_gnt_q;
      gnt_d       = 2'b00;
      sel_d       = sel;
      busy_d      = busy;
`ifdef SWEEP_EN
      idle_cnt_d  = idle_cnt_q;
      step_d      = step_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (elig != 2'b00) begin
               gnt_d      = win_b ? 2'b10 : 2'b01;
               last_gnt_d = win_b;
               sel_d      = win_pos;
               if (win_pos != sel) begin
                  state_d     = HOLD;
                  frame_cnt_d = 8'd0;
                  busy_d      = 1'b1;
               end
            end
`ifdef SWEEP_EN
            if (req != 2'b00) begin
               idle_cnt_d = 8'd0;
            end else if (frame_tick) begin
               if (idle_cnt_q == IDLE_LAST) begin
                  state_d     = SWEEP;
                  frame_cnt_d = 8'd0;
                  idle_cnt_d  = 8'd0;
                  step_d      = 3'd0;
                  sel_d       = sweep_pos(3'd0);
                  busy_d      = 1'b1;
               end else begin
                  idle_cnt_d = sat_inc(idle_cnt_q);
               end
            end
`endif
         end
         HOLD: begin
            if (frame_tick) begin
               if (frame_cnt_q == HOLD_LAST) begin
                  state_d     = IDLE;
                  frame_cnt_d = 8'd0;
                  busy_d      = 1'b0;
`ifdef SWEEP_EN
                  idle_cnt_d  = 8'd0;
`endif
               end else begin
                  frame_cnt_d = sat_inc(frame_cnt_q);
               end
            end
         end
`ifdef SWEEP_EN
         SWEEP: begin
            if (req != 2'b00) begin
               // Abort: back to IDLE, sel keeps the last sweep position.
               state_d     = IDLE;
               frame_cnt_d = 8'd0;
               idle_cnt_d  = 8'd0;
               busy_d      = 1'b0;
            end else if (frame_tick) begin
               if (frame_cnt_q == STEP_LAST) begin
                  frame_cnt_d = 8'd0;
                  if (step_q == 3'd4) begin
                     state_d    = IDLE;
                     idle_cnt_d = 8'd0;
                     busy_d     = 1'b0;
                  end else begin
                     step_d = step_q + 3'd1;
                     sel_d  = sweep_pos(step_q + 3'd1);
                  end
               end else begin
                  frame_cnt_d = sat_inc(frame_cnt_q);
               end
            end
         end
`endif
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         frame_cnt_q <= 8'd0;
         last_gnt_q  <= 1'b1;
         gnt         <= 2'b00;
         sel         <= 2'd0;
         busy        <= 1'b0;
`ifdef SWEEP_EN
         idle_cnt_q  <= 8'd0;
         step_q      <= 3'd0;
`endif
      end else begin
         state_q     <= state_d;
         frame_cnt_q <= frame_cnt_d;
         last_gnt_q  <= last_gnt_d;
         gnt         <= gnt_d;
         sel         <= sel_d;
         busy        <= busy_d;
`ifdef SWEEP_EN
         idle_cnt_q  <= idle_cnt_d;
         step_q      <= step_d;
`endif
      end
   end

endmodule

// File: tb/tb_servo_sched.sv
// -----------------------------------------------------------------------------
// tb_servo_sched
//   Directed scenarios followed by randomized requests, each cycle compared
//   with a behavioural model expressed as frames-remaining countdowns and a
//   queue of pending sweep positions. Sweep scenarios run when SWEEP_EN is
//   defined.
// -----------------------------------------------------------------------------
module tb_servo_sched;
   localparam int HOLD = 3;
   localparam int IDLE = 4;
   localparam int STEP = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       frame_tick = 1'b0;
   logic [1:0] req = 2'b00;
   logic [1:0] pos_a = 2'd0;
   logic [1:0] pos_b = 2'd0;
   logic [1:0] gnt;
   logic       busy;
   logic [1:0] sel;

   always #5 clk = ~clk;

   servo_sched #(
      .HOLD_FRAMES(HOLD),
      .IDLE_FRAMES(IDLE),
      .STEP_FRAMES(STEP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .frame_tick(frame_tick),
      .req(req),
      .pos_a(pos_a),
      .pos_b(pos_b),
      .gnt(gnt),
      .busy(busy),
      .sel(sel)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // ---------------- reference model ----------------
   int         hold_left;     // frames still to hold; 0 = not holding
   int         sweep_left;    // frames left in current sweep step
   int         idle_seen;     // idle frames observed with no request
   bit         sweep_on;
   bit         last_b;        // 1 = B granted last
   logic [1:0] m_sel;
   logic [1:0] m_gnt;
   int         sweep_q[$];    // sweep positions still to apply

   task automatic model_reset();
      hold_left = 0; sweep_left = 0; idle_seen = 0; sweep_on = 0;
      last_b = 1'b1; m_sel = 2'd0; m_gnt = 2'b00;
      sweep_q.delete();
   endtask

   task automatic model_update();
      logic [1:0] prev_gnt;
      logic [1:0] elig;
      logic [1:0] p;
      bit         win_b;
      prev_gnt = m_gnt;
      m_gnt    = 2'b00;
      if (sweep_on) begin
         if (req != 2'b00) begin
            sweep_on = 0; idle_seen = 0;
         end else if (frame_tick) begin
            sweep_left--;
            if (sweep_left == 0) begin
               if (sweep_q.size() == 0) begin
                  sweep_on = 0; idle_seen = 0;
               end else begin
                  m_sel = 2'(sweep_q.pop_front());
                  sweep_left = STEP;
               end
            end
         end
      end else if (hold_left > 0) begin
         if (frame_tick) hold_left--;
      end else begin
         elig = req & ~prev_gnt;
         if (elig != 2'b00) begin
            win_b  = (elig == 2'b11) ? !last_b : elig[1];
            p      = win_b ? pos_b : pos_a;
            if (p == 2'd3) p = 2'd0;
            m_gnt  = win_b ? 2'b10 : 2'b01;
            last_b = win_b;
            if (p != m_sel) hold_left = HOLD;
            m_sel  = p;
         end
`ifdef SWEEP_EN
         if (req != 2'b00) idle_seen = 0;
         else if (frame_tick) begin
            idle_seen++;
            if (idle_seen == IDLE) begin
               sweep_on = 1; idle_seen = 0; m_sel = 2'd0;
               sweep_q = '{2, 1, 2, 0};
               sweep_left = STEP;
            end
         end
`endif
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Drive inputs (called #1 after an edge), take one edge, compare to model.
   task automatic step(input logic [1:0] r, input logic [1:0] pa,
                       input logic [1:0] pb, input logic t);
      req = r; pos_a = pa; pos_b = pb; frame_tick = t;
      @(posedge clk);
      model_update();
      #1;
      check("gnt_model",  8'(gnt),  8'(m_gnt));
      check("sel_model",  8'(sel),  8'(m_sel));
      check("busy_model", 8'(busy), 8'((hold_left > 0) || sweep_on));
   endtask

   task automatic drain();
      for (int k = 0; k < HOLD; k++) begin
         step(2'b00, 2'd0, 2'd0, 1'b1);
         step(2'b00, 2'd0, 2'd0, 1'b0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 2'b00; frame_tick = 1'b0;
      #1;
      model_reset();
      check("rst_gnt",  8'(gnt),  8'd0);
      check("rst_sel",  8'(sel),  8'd0);
      check("rst_busy", 8'(busy), 8'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [1:0] r, pa, pb;
      logic       t;
      int         rate;
`ifdef SWEEP_EN
      int         seq[4];
      seq = '{2, 1, 2, 0};
`endif

      // 1: single request, hold for HOLD frames
      do_reset();
      step(2'b01, 2'd1, 2'd0, 1'b0);
      check("t1_gnt",  8'(gnt),  8'b01);
      check("t1_sel",  8'(sel),  8'd1);
      check("t1_busy", 8'(busy), 8'd1);
      for (int k = 0; k < HOLD; k++) begin
         step(2'b00, 2'd1, 2'd0, 1'b1);
         check("t1_busy_tick", 8'(busy), (k < HOLD - 1) ? 8'd1 : 8'd0);
         step(2'b00, 2'd1, 2'd0, 1'b0);
      end

      // 2: both request from reset -> A first, B pending through HOLD
      do_reset();
      step(2'b11, 2'd2, 2'd1, 1'b0);
      check("t2_gnt_a", 8'(gnt),  8'b01);
      check("t2_sel_a", 8'(sel),  8'd2);
      check("t2_busy",  8'(busy), 8'd1);
      for (int k = 0; k < HOLD; k++) begin
         step(2'b10, 2'd2, 2'd1, 1'b1);
         check("t2_gnt_hold", 8'(gnt), 8'b00);
         check("t2_busy_tick", 8'(busy), (k < HOLD - 1) ? 8'd1 : 8'd0);
         if (k < HOLD - 1) step(2'b10, 2'd2, 2'd1, 1'b0);
      end
      step(2'b10, 2'd2, 2'd1, 1'b0);
      check("t2_gnt_b", 8'(gnt), 8'b10);
      check("t2_sel_b", 8'(sel), 8'd1);
      drain();

      // 3: no-op grant, then immediate grant to B
      step(2'b01, 2'd2, 2'd0, 1'b0);
      drain();
      step(2'b01, 2'd2, 2'd0, 1'b0);
      check("t3_gnt_noop",  8'(gnt),  8'b01);
      check("t3_busy_noop", 8'(busy), 8'd0);
      check("t3_sel_noop",  8'(sel),  8'd2);
      step(2'b10, 2'd2, 2'd0, 1'b0);
      check("t3_gnt_b",  8'(gnt),  8'b10);
      check("t3_sel_b",  8'(sel),  8'd0);
      check("t3_busy_b", 8'(busy), 8'd1);
      drain();

      // 4: pos 3 maps to 0; reset mid-HOLD while gnt is high
      step(2'b01, 2'd1, 2'd0, 1'b0);
      drain();
      step(2'b01, 2'd3, 2'd0, 1'b0);
      check("t4_sel_map",  8'(sel),  8'd0);
      check("t4_busy_map", 8'(busy), 8'd1);
      drain();
      step(2'b10, 2'd0, 2'd2, 1'b0);
      check("t4_gnt_pre", 8'(gnt), 8'b10);
      check("t4_sel_pre", 8'(sel), 8'd2);
      do_reset();
      step(2'b11, 2'd1, 2'd2, 1'b0);
      check("t4_lastgnt_rst", 8'(gnt), 8'b01);
      drain();

`ifdef SWEEP_EN
      // 5: idle frames start a full sweep
      do_reset();
      for (int k = 1; k <= IDLE; k++) begin
         step(2'b00, 2'd0, 2'd0, 1'b1);
         check("t5_busy_idle", 8'(busy), (k == IDLE) ? 8'd1 : 8'd0);
         step(2'b00, 2'd0, 2'd0, 1'b0);
      end
      check("t5_sel_entry", 8'(sel), 8'd0);
      for (int j = 1; j <= 5 * STEP; j++) begin
         step(2'b00, 2'd0, 2'd0, 1'b1);
         if (j % STEP == 0 && j < 5 * STEP) check("t5_sel_step", 8'(sel), 8'(seq[j / STEP - 1]));
         check("t5_busy_sweep", 8'(busy), (j < 5 * STEP) ? 8'd1 : 8'd0);
         step(2'b00, 2'd0, 2'd0, 1'b0);
      end

      // 6: request aborts the sweep at sel=1
      for (int k = 1; k <= IDLE; k++) begin
         step(2'b00, 2'd0, 2'd0, 1'b1);
         step(2'b00, 2'd0, 2'd0, 1'b0);
      end
      for (int j = 1; j <= 2 * STEP; j++) begin
         step(2'b00, 2'd0, 2'd0, 1'b1);
         step(2'b00, 2'd0, 2'd0, 1'b0);
      end
      check("t6_sel_pre", 8'(sel), 8'd1);
      step(2'b10, 2'd0, 2'd1, 1'b0);
      check("t6_busy_abort", 8'(busy), 8'd0);
      check("t6_gnt_abort",  8'(gnt),  8'b00);
      step(2'b10, 2'd0, 2'd1, 1'b0);
      check("t6_gnt_b", 8'(gnt),  8'b10);
      check("t6_sel_b", 8'(sel),  8'd1);
      check("t6_busy",  8'(busy), 8'd0);
      step(2'b00, 2'd0, 2'd0, 1'b0);
`endif

      // Randomized requesters against the model
      r = 2'b00; pa = 2'd0; pb = 2'd0; t = 1'b0;
      for (int c = 0; c < 800; c++) begin
         rate = (c < 350) ? 4 : 40;
         if (gnt[0]) r[0] = 1'b0;
         else if (!r[0] && $urandom_range(0, rate - 1) == 0) begin
            r[0] = 1'b1; pa = 2'($urandom_range(0, 3));
         end else if (r[0] && $urandom_range(0, 60) == 0) r[0] = 1'b0;
         if (gnt[1]) r[1] = 1'b0;
         else if (!r[1] && $urandom_range(0, rate - 1) == 0) begin
            r[1] = 1'b1; pb = 2'($urandom_range(0, 3));
         end else if (r[1] && $urandom_range(0, 60) == 0) r[1] = 1'b0;
         t = !t && ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
            r = 2'b00; t = 1'b0;
         end
         step(r, pa, pb, t);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
